// File: rtl/if_id_decode_pkg.sv
// Shared IF/ID definitions: opcodes, immediate-extender selects, stage state
// encoding and the registered entry format.
package if_id_decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2,
    IMM_U = 2'd3
  } imm_sel_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    imm_sel_t    imm_ctrl;
    logic        uses_imm;
    logic        illegal;
  } entry_t;

endpackage

// File: rtl/if_id_decode_imm.sv
// Combinational opcode decode to immediate-extender controls.
module imm_decoder
  import if_id_decode_pkg::*;
(
  input  logic [6:0] i_opcode,
  output imm_sel_t   o_imm_ctrl,
  output logic       o_uses_imm,
  output logic       o_illegal
);

  always_comb begin
    o_imm_ctrl = IMM_I;
    o_uses_imm = 1'b0;
    o_illegal  = 1'b0;
    case (i_opcode)
      OP_LOAD, OP_IMM, OP_JALR: o_uses_imm = 1'b1;
      OP_STORE:  begin o_imm_ctrl = IMM_S; o_uses_imm = 1'b1; end
      OP_BRANCH: begin o_imm_ctrl = IMM_B; o_uses_imm = 1'b1; end
      OP_LUI, OP_AUIPC: begin o_imm_ctrl = IMM_U; o_uses_imm = 1'b1; end
      OP_OP:     ;
      // jal has no extender format here, so it is flagged like any unknown opcode
      OP_JAL:    o_illegal = 1'b1;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/if_id_decode.sv
// IF/ID pipeline register with a one-entry skid buffer; decode is done on the
// input path and carried with each entry so all outputs come from flops.
module if_id_decode
  import if_id_decode_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrIn,
  input  logic [31:0] PCIn,
  input  logic        InValid,
  output logic        InReady,
  input  logic        Flush,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [1:0]  ImmControl,
  output logic        UsesImm,
  output logic        IllegalInstr,
  output logic        OutValid,
  input  logic        OutReady
);

  localparam entry_t NOP_ENTRY = '{instr: NOP_INSTR, pc: 32'd0, imm_ctrl: IMM_I,
                                   uses_imm: 1'b0, illegal: 1'b0};

  state_t   r_state, w_state_nxt;
  entry_t   r_main, r_skid, w_main_nxt, w_skid_nxt, w_in;
  logic     r_valid, w_valid_nxt;
  logic     w_accept, w_xfer;
  imm_sel_t w_imm_ctrl;
  logic     w_uses_imm, w_illegal;

  imm_decoder u_dec (
    .i_opcode   (InstrIn[6:0]),
    .o_imm_ctrl (w_imm_ctrl),
    .o_uses_imm (w_uses_imm),
    .o_illegal  (w_illegal)
  );

  assign w_in     = '{instr: InstrIn, pc: PCIn, imm_ctrl: w_imm_ctrl,
                      uses_imm: w_uses_imm, illegal: w_illegal};
  assign InReady  = (r_state != ST_TWO);
  assign w_accept = InValid & InReady;
  assign w_xfer   = r_valid & OutReady;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    w_valid_nxt = r_valid;
    case (r_state)
      ST_EMPTY: if (w_accept) begin
        w_state_nxt = ST_ONE;
        w_main_nxt  = w_in;
        w_valid_nxt = 1'b1;
      end
      ST_ONE: begin
        if (w_accept && !w_xfer) begin
          w_state_nxt = ST_TWO;
          w_skid_nxt  = w_in;
        end else if (w_accept && w_xfer) begin
          w_main_nxt  = w_in;
        end else if (w_xfer) begin
          w_state_nxt = ST_EMPTY;
          w_main_nxt  = NOP_ENTRY;
          w_valid_nxt = 1'b0;
        end
      end
      ST_TWO: if (w_xfer) begin
        w_state_nxt = ST_ONE;
        w_main_nxt  = r_skid;
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_main_nxt  = NOP_ENTRY;
        w_valid_nxt = 1'b0;
      end
    endcase
    // Flush wins over any accept/transfer decided above
    if (Flush) begin
      w_state_nxt = ST_EMPTY;
      w_main_nxt  = NOP_ENTRY;
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
      r_main  <= NOP_ENTRY;
      r_skid  <= NOP_ENTRY;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign Instr        = r_main.instr;
  assign PC           = r_main.pc;
  assign ImmControl   = r_main.imm_ctrl;
  assign UsesImm      = r_main.uses_imm;
  assign IllegalInstr = r_main.illegal;
  assign OutValid     = r_valid;

endmodule
